pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Next-PC source controller for the summer CPU. Sits between the instruction decoder and the `PC` register. Each cycle it arbitrates between sequential fetch, branch, jump, jump-register, undefined-instruction exception and external interrupt, and drives `PCSrc`, the PC write enable and the exception-PC save strobe. It tracks kernel/user mode through `PC[31]` and enforces an interrupt hold-off window after returning to user mode.

## Interface
- `HOLDOFF`, default 4: cycles interrupts stay masked after kernel→user return (0 to 15).
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `is_branch` input 1: decoded conditional branch.
- `ALUOut0` input 1: branch condition from ALU (1 = taken).
- `is_j` input 1: decoded j/jal.
- `is_jr` input 1: decoded jr/jalr.
- `is_undef` input 1: undefined opcode/funct.
- `PC31` input 1: current `PC[31]`, 1 = kernel mode.
- `stall` input 1: memory wait; freezes the PC.
- `irq` input 1: external interrupt request, level, may be asynchronous.
- `PCSrc` output 3: 000 PC+4, 001 branch (`ConBA`), 010 jump (`JT`), 011 jr (`DatabusA`), 100 interrupt vector (ILLOP), 101 exception vector (XADR).
- `PCWrite` output 1: PC register enable.
- `epc_we` output 1: save PC+4 into $k0 this cycle.
- `irq_ack` output 1: one-cycle interrupt acknowledge.
- `in_kernel` output 1: registered mode flag (state KERNEL).

## Operation
- FSM states: RUN, KERNEL, HOLD.
- Edge detect: register `irq_q` = sampled irq. `irq_rise` = sampled irq & ~`irq_q`. `pending` sets on `irq_rise` and clears on `irq_ack`. If both happen in the same cycle, `pending` stays 1.
- Priority for `PCSrc` when `stall`=0:
  1. `is_undef`: 101, any state.
  2. `pending` & state RUN & ~`PC31`: 100.
  3. `is_jr`: 011.
  4. `is_j`: 010.
  5. `is_branch` & `ALUOut0`: 001.
  6. Otherwise 000.
- `is_branch` with `ALUOut0`=0 gives 000.
- Dispatch of 100 or 101 asserts `epc_we`=1. Dispatch of 100 also asserts `irq_ack`=1. Next state is KERNEL.
- KERNEL: interrupts masked; exceptions still taken (101, `epc_we`=1, stay in KERNEL). On observing `PC31`=0 (return via jr), go to HOLD with counter=`HOLDOFF`, or straight to RUN if `HOLDOFF`=0.
- HOLD: counter decrements each non-stall cycle and goes to RUN when it reaches 1→0 transition. Interrupts masked. `is_undef` → dispatch 101 and go to KERNEL.
- `stall`=1:
  - `PCWrite`=0, `epc_we`=0, `irq_ack`=0.
  - No state or counter change; `pending` still sets.
  - `PCSrc` still reflects the priority result.
- `PCWrite`=1 whenever `stall`=0 and `reset`=0.

## Timing
- Reset values:
  - `PCSrc`=000, `PCWrite`=0, `epc_we`=0, `irq_ack`=0, `in_kernel`=0.
  - State RUN, `pending`=0, `irq_q`=0, counter=0.
  - Outputs are combinationally gated by `reset`.
- Branch, jump and undef decisions are combinational, with zero-cycle latency.
- Interrupt latency, without sync:
  - `irq` high at edge N sets `pending` at edge N+1.
  - Dispatch 100 appears in cycle N+1 (after edge N+1) if RUN, `PC31`=0 and `stall`=0.
  - `pending` is cleared at edge N+2.
- `irq` held high produces one interrupt only; a new request needs a low then high.
- A pending interrupt that arrives during KERNEL or HOLD waits and dispatches on the first RUN cycle.
- `reset` mid-trap: the next cycle is RUN, `pending`=0, and the counter is cleared.

## Configuration
- `PC_CTRL_IRQ_SYNC_EN` defined: two-flop synchronizer on `irq` ahead of the edge detect. Interrupt latency grows by 2 cycles (dispatch in cycle N+3). Synchronizer flops reset to 0.
- Undefined: `irq` is edge-detected directly, with latency as in Timing.

## Test plan
- **Reset and sequential fetch.** Assert reset 2 cycles, release with all decode inputs 0. Expect `PCSrc`=000 and `PCWrite`=0 during reset, then `PCSrc`=000 and `PCWrite`=1.
- **Branch and jump decode.** Apply in turn:
  - `is_branch`=1, `ALUOut0`=1 → 001.
  - `ALUOut0`=0 → 000.
  - `is_j` → 010.
  - `is_jr` → 011.
  - `is_jr`+`is_j` together → 011.
- **Undefined instruction.** `is_undef`=1 with `is_branch`=1, `ALUOut0`=1. Expect 101, `epc_we`=1, `irq_ack`=0, and `in_kernel`=1 on the next cycle.
- **Interrupt dispatch, no sync.** Pulse `irq` in RUN with `PC31`=0. Expect 100, `epc_we`=1 and `irq_ack`=1 exactly one cycle after sampling. Hold `irq` high 10 cycles: exactly one ack.
- **Interrupt deferral and hold-off.** Raise `irq` while in KERNEL (`PC31`=1). Drop `PC31` to 0 with `HOLDOFF`=4. Expect no dispatch for 4 cycles, then 100 on the first RUN cycle.
- **Stall.** `stall`=1 while `pending`=1 and `is_undef`=1. Expect `PCWrite`=0, `epc_we`=0 and `irq_ack`=0, with state unchanged. Releasing `stall` gives 101 first; the interrupt is not dispatched while in KERNEL.

Source files
------------

// File: rtl/pc_ctrl.sv
// Next-PC source controller: arbitrates sequential/branch/jump/jr/exception/interrupt
// and tracks kernel mode. Define PC_CTRL_IRQ_SYNC_EN to add a two-flop irq synchronizer.
module pc_ctrl #(
   parameter int HOLDOFF = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       is_branch,
   input  logic       ALUOut0,
   input  logic       is_j,
   input  logic       is_jr,
   input  logic       is_undef,
   input  logic       PC31,
   input  logic       stall,
   input  logic       irq,
   output logic [2:0] PCSrc,
   output logic       PCWrite,
   output logic       epc_we,
   output logic       irq_ack,
   output logic       in_kernel
);

   typedef enum logic [1:0] {RUN, KERNEL, HOLD} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       pending;
   logic       irq_in;
   logic       irq_s;
   logic       irq_q;
   logic       irq_rise;
   logic       take_irq;
   logic       active;
   logic [2:0] sel;

`ifdef PC_CTRL_IRQ_SYNC_EN
   logic [1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], irq};
      end
   end

   assign irq_in = sync_reg[1];
`else
   assign irq_in = irq;
`endif

   assign irq_rise = irq_s & ~irq_q;
   assign take_irq = pending & (state == RUN) & ~PC31;
   assign active   = ~reset & ~stall;

   always_comb begin
      sel = 3'b000;
      if (is_undef)                 sel = 3'b101;
      else if (take_irq)            sel = 3'b100;
      else if (is_jr)               sel = 3'b011;
      else if (is_j)                sel = 3'b010;
      else if (is_branch & ALUOut0) sel = 3'b001;
   end

   assign PCSrc     = reset ? 3'b000 : sel;
   assign PCWrite   = active;
   assign epc_we    = active & (is_undef | take_irq);
   assign irq_ack   = active & ~is_undef & take_irq;
   assign in_kernel = (state == KERNEL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         cnt     <= 4'd0;
         pending <= 1'b0;
         irq_s   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irq_s   <= irq_in;
         irq_q   <= irq_s;
         // A new edge wins over a simultaneous acknowledge.
         pending <= irq_rise | (pending & ~irq_ack);
         if (!stall) begin
            if (is_undef | take_irq) begin
               state <= KERNEL;
            end else begin
               case (state)
                  KERNEL: begin
                     if (!PC31) begin
                        if (HOLDOFF == 0) begin
                           state <= RUN;
                        end else begin
                           state <= HOLD;
                           cnt   <= 4'(HOLDOFF);
                        end
                     end
                  end
                  HOLD: begin
                     if (cnt <= 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                     end else begin
                        cnt <= cnt - 4'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl (HOLDOFF = 4).
module tb_pc_ctrl;

   logic       clk = 1'b0;
   logic       reset, is_branch, ALUOut0, is_j, is_jr, is_undef, PC31, stall, irq;
   logic [2:0] PCSrc;
   logic       PCWrite, epc_we, irq_ack, in_kernel;
   logic [2:0] acks;
   int         nvec = 0;
   int         nerr = 0;

`ifdef PC_CTRL_IRQ_SYNC_EN
   localparam int SX = 2;
`else
   localparam int SX = 0;
`endif

   always #5 clk = ~clk;

   pc_ctrl #(.HOLDOFF(4)) dut (
      .clk(clk), .reset(reset), .is_branch(is_branch), .ALUOut0(ALUOut0),
      .is_j(is_j), .is_jr(is_jr), .is_undef(is_undef), .PC31(PC31),
      .stall(stall), .irq(irq), .PCSrc(PCSrc), .PCWrite(PCWrite),
      .epc_we(epc_we), .irq_ack(irq_ack), .in_kernel(in_kernel)
   );

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic dec(input logic b, input logic a, input logic j, input logic jr, input logic u);
      is_branch = b;
      ALUOut0   = a;
      is_j      = j;
      is_jr     = jr;
      is_undef  = u;
   endtask

   initial begin
      reset = 1'b1; dec(0, 0, 0, 0, 0); PC31 = 1'b0; stall = 1'b0; irq = 1'b0;

      // reset holds outputs quiet even with a decode input active
      cyc; is_undef = 1'b1; #1;
      chk3("rst_pcsrc", PCSrc, 3'b000);
      chk1("rst_pcwrite", PCWrite, 1'b0);
      chk1("rst_epc", epc_we, 1'b0);
      chk1("rst_ack", irq_ack, 1'b0);
      chk1("rst_kernel", in_kernel, 1'b0);
      cyc; is_undef = 1'b0; #1;
      chk3("rst2_pcsrc", PCSrc, 3'b000);
      chk1("rst2_pcwrite", PCWrite, 1'b0);

      cyc; reset = 1'b0; #1;
      chk3("seq_pcsrc", PCSrc, 3'b000);
      chk1("seq_pcwrite", PCWrite, 1'b1);

      cyc; dec(1, 1, 0, 0, 0); #1; chk3("br_taken", PCSrc, 3'b001);
      cyc; dec(1, 0, 0, 0, 0); #1; chk3("br_not_taken", PCSrc, 3'b000);
      cyc; dec(0, 0, 1, 0, 0); #1; chk3("jump", PCSrc, 3'b010);
      cyc; dec(0, 0, 0, 1, 0); #1; chk3("jr", PCSrc, 3'b011);
      cyc; dec(0, 0, 1, 1, 0); #1; chk3("jr_over_j", PCSrc, 3'b011);
      cyc; dec(1, 1, 0, 1, 0); #1; chk3("jr_over_br", PCSrc, 3'b011);

      // irq held high 12 cycles in RUN: one dispatch only
      cyc; dec(0, 0, 0, 0, 0); irq = 1'b1; #1;
      chk3("irq_c0", PCSrc, 3'b000);
      acks = 3'd0;
      for (int i = 1; i <= 12; i++) begin
         cyc; #1;
         if (irq_ack) acks = acks + 3'd1;
         if (i == 2 + SX) begin
            chk3("irq_pcsrc", PCSrc, 3'b100);
            chk1("irq_epc", epc_we, 1'b1);
            chk1("irq_ack", irq_ack, 1'b1);
         end else begin
            chk3("irq_idle", PCSrc, 3'b000);
         end
         if (i == 3 + SX) chk1("irq_kernel", in_kernel, 1'b1);
      end
      chk3("irq_one_ack", acks, 3'd1);

      // undefined instruction beats a taken branch
      cyc; irq = 1'b0; dec(1, 1, 0, 0, 1); #1;
      chk3("undef_pcsrc", PCSrc, 3'b101);
      chk1("undef_epc", epc_we, 1'b1);
      chk1("undef_ack", irq_ack, 1'b0);
      chk1("undef_kern0", in_kernel, 1'b0);

      // irq raised in kernel is deferred through the hold-off window
      cyc; dec(0, 0, 0, 0, 0); PC31 = 1'b1; irq = 1'b1; #1;
      chk1("undef_kern1", in_kernel, 1'b1);
      chk3("kern_pcsrc", PCSrc, 3'b000);
      cyc; PC31 = 1'b0; #1;
      chk1("ret_kern", in_kernel, 1'b1);
      chk1("ret_ack", irq_ack, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc; #1;
         chk1("hold_kern", in_kernel, 1'b0);
         chk3("hold_pcsrc", PCSrc, 3'b000);
         chk1("hold_ack", irq_ack, 1'b0);
      end
      cyc; #1;
      chk3("defer_pcsrc", PCSrc, 3'b100);
      chk1("defer_ack", irq_ack, 1'b1);
      chk1("defer_epc", epc_we, 1'b1);

      cyc; irq = 1'b0; PC31 = 1'b1; #1;
      chk1("defer_kern", in_kernel, 1'b1);
      chk3("defer_kern_pcsrc", PCSrc, 3'b000);
      for (int i = 1; i <= 5; i++) begin
         cyc; PC31 = 1'b0; #1;
         chk1("ret2_ack", irq_ack, 1'b0);
      end

      // stall with undef and an arriving interrupt
      cyc; stall = 1'b1; irq = 1'b1; dec(0, 0, 0, 0, 1); #1;
      chk3("stall_pcsrc", PCSrc, 3'b101);
      chk1("stall_pcwrite", PCWrite, 1'b0);
      for (int i = 1; i <= 2 + SX; i++) begin
         cyc; #1;
         chk3("stall_pcsrc", PCSrc, 3'b101);
         chk1("stall_pcwrite", PCWrite, 1'b0);
         chk1("stall_epc", epc_we, 1'b0);
         chk1("stall_ack", irq_ack, 1'b0);
         chk1("stall_kern", in_kernel, 1'b0);
      end
      cyc; stall = 1'b0; #1;
      chk3("unstall_pcsrc", PCSrc, 3'b101);
      chk1("unstall_epc", epc_we, 1'b1);
      chk1("unstall_ack", irq_ack, 1'b0);
      chk1("unstall_pcwrite", PCWrite, 1'b1);
      cyc; dec(0, 0, 0, 0, 0); PC31 = 1'b1; irq = 1'b0; #1;
      chk1("post_kern", in_kernel, 1'b1);
      chk3("post_pcsrc", PCSrc, 3'b000);
      chk1("post_ack", irq_ack, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         cyc; PC31 = 1'b0; #1;
         chk3("post_hold_pcsrc", PCSrc, 3'b000);
         chk1("post_hold_ack", irq_ack, 1'b0);
      end
      cyc; #1;
      chk3("late_irq_pcsrc", PCSrc, 3'b100);
      chk1("late_irq_ack", irq_ack, 1'b1);

      // reset while in kernel
      cyc; reset = 1'b1; #1;
      chk1("mid_kern", in_kernel, 1'b1);
      chk3("mid_rst_pcsrc", PCSrc, 3'b000);
      chk1("mid_rst_pcwrite", PCWrite, 1'b0);
      cyc; reset = 1'b0; #1;
      chk1("mid_after_kern", in_kernel, 1'b0);
      chk3("mid_after_pcsrc", PCSrc, 3'b000);
      chk1("mid_after_pcwrite", PCWrite, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
